// File: rtl/plic_claim_sequencer_if.sv
// Bundles the CPU access port, the shared PLIC register port, and the
// interrupt-presentation / statistics signals of the claim sequencer.
interface plic_claim_sequencer_if;
  logic        cpu_req;
  logic        cpu_read_en;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_wstrb;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;

  logic [31:0] plic_addr;
  logic [31:0] plic_wdata;
  logic [3:0]  plic_wstrb;
  logic        plic_read_en;
  logic [31:0] plic_rdata;
  logic        plic_external_irq;

  logic        engine_en;
  logic        irq_valid;
  logic [4:0]  irq_id;
  logic        done_valid;
  logic [4:0]  done_id;

  logic [15:0] claim_count;
  logic [7:0]  spurious_count;

  modport slave (
    input  cpu_req, cpu_read_en, cpu_addr, cpu_wdata, cpu_wstrb,
    output cpu_ready, cpu_rdata,
    output plic_addr, plic_wdata, plic_wstrb, plic_read_en,
    input  plic_rdata, plic_external_irq,
    input  engine_en,
    output irq_valid, irq_id,
    input  done_valid, done_id,
    output claim_count, spurious_count
  );

  modport master (
    output cpu_req, cpu_read_en, cpu_addr, cpu_wdata, cpu_wstrb,
    input  cpu_ready, cpu_rdata,
    input  plic_addr, plic_wdata, plic_wstrb, plic_read_en,
    output plic_rdata, plic_external_irq,
    output engine_en,
    input  irq_valid, irq_id,
    output done_valid, done_id,
    input  claim_count, spurious_count
  );
endinterface

// File: rtl/plic_claim_sequencer.sv
// Automatic PLIC claim/complete engine sharing one PLIC register port with
// the CPU; contested cycles go to whichever requester lost the last contest.
module plic_claim_sequencer #(
  parameter logic [31:0] CLAIM_ADDR = 32'h0C200004,
  parameter int unsigned HOLDOFF    = 2
) (
  input logic                    clk,
  input logic                    rst,
  plic_claim_sequencer_if.slave  bus
);

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] CLAIM_REQ    = 2'd1;
  localparam logic [1:0] PRESENT      = 2'd2;
  localparam logic [1:0] COMPLETE_REQ = 2'd3;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [4:0]  held_id;
  logic [3:0]  holdoff;
  logic [15:0] claim_cnt;
  logic [7:0]  spur_cnt;
  logic        cpu_won_last;

  logic eng_req;
  logic contest;
  logic eng_gnt;
  logic cpu_gnt;
  logic claim_gnt;
  logic complete_gnt;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // The engine only wants the port while it has a claim read or complete write pending.
  assign eng_req      = (state == CLAIM_REQ) || (state == COMPLETE_REQ);
  assign contest      = eng_req && bus.cpu_req;
  assign eng_gnt      = eng_req && (!bus.cpu_req || cpu_won_last);
  assign cpu_gnt      = bus.cpu_req && !eng_gnt && !rst;
  assign claim_gnt    = eng_gnt && (state == CLAIM_REQ);
  assign complete_gnt = eng_gnt && (state == COMPLETE_REQ);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:
        if (bus.engine_en && bus.plic_external_irq && (holdoff == 4'd0))
          state_nxt = CLAIM_REQ;
      CLAIM_REQ:
        if (eng_gnt)
          state_nxt = (bus.plic_rdata[4:0] == 5'd0) ? IDLE : PRESENT;
      PRESENT:
        if (bus.done_valid && (bus.done_id == held_id))
          state_nxt = COMPLETE_REQ;
      COMPLETE_REQ:
        if (eng_gnt)
          state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      held_id      <= 5'd0;
      holdoff      <= 4'd0;
      claim_cnt    <= 16'd0;
      spur_cnt     <= 8'd0;
      cpu_won_last <= 1'b1;
    end else begin
      state <= state_nxt;
      if (contest)
        cpu_won_last <= !eng_gnt;
      if (complete_gnt)
        holdoff <= 4'(HOLDOFF);
      else if (holdoff != 4'd0)
        holdoff <= holdoff - 4'd1;
      // An ID of zero from the claim register means nothing was pending.
      if (claim_gnt) begin
        held_id <= bus.plic_rdata[4:0];
        if (bus.plic_rdata[4:0] == 5'd0)
          spur_cnt <= sat_inc8(spur_cnt);
        else
          claim_cnt <= claim_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    bus.plic_addr    = 32'h0;
    bus.plic_wdata   = 32'h0;
    bus.plic_wstrb   = 4'h0;
    bus.plic_read_en = 1'b0;
    if (claim_gnt) begin
      bus.plic_addr    = CLAIM_ADDR;
      bus.plic_read_en = 1'b1;
    end else if (complete_gnt) begin
      bus.plic_addr  = CLAIM_ADDR;
      bus.plic_wdata = {27'b0, held_id};
      bus.plic_wstrb = 4'hF;
    end else if (cpu_gnt) begin
      bus.plic_addr    = bus.cpu_addr;
      bus.plic_wdata   = bus.cpu_wdata;
      bus.plic_wstrb   = bus.cpu_wstrb;
      bus.plic_read_en = bus.cpu_read_en;
    end
  end

  assign bus.cpu_ready      = cpu_gnt;
  assign bus.cpu_rdata      = cpu_gnt ? bus.plic_rdata : 32'h0;
  assign bus.irq_valid      = (state == PRESENT);
  assign bus.irq_id         = (state == PRESENT) ? held_id : 5'd0;
  assign bus.claim_count    = claim_cnt;
  assign bus.spurious_count = spur_cnt;

endmodule

// File: tb/tb_plic_claim_sequencer.sv
// Bench for plic_claim_sequencer: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_plic_claim_sequencer;
  localparam logic [31:0] CLAIM_ADDR = 32'h0C200004;
  localparam int          HOLDOFF    = 2;

  logic clk = 1'b0;
  logic rst;

  plic_claim_sequencer_if bus();

  plic_claim_sequencer #(.CLAIM_ADDR(CLAIM_ADDR), .HOLDOFF(HOLDOFF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Model: which engine transaction is outstanding, plus counters.
  bit m_claim_pend, m_holding, m_compl_pend, m_cpu_won_last;
  int m_id, m_holdoff, m_claims, m_spur;
  bit m_eng_wants, m_eng_wins, m_cpu_wins;

  logic        e_cpu_ready, e_read_en, e_irq_valid;
  logic [31:0] e_cpu_rdata, e_addr, e_wdata;
  logic [3:0]  e_wstrb;
  logic [4:0]  e_irq_id;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_claim_pend   = 0;
    m_holding      = 0;
    m_compl_pend   = 0;
    m_cpu_won_last = 1;
    m_id           = 0;
    m_holdoff      = 0;
    m_claims       = 0;
    m_spur         = 0;
  endfunction

  function automatic void model_predict();
    m_eng_wants = !rst && (m_claim_pend || m_compl_pend);
    m_eng_wins  = m_eng_wants && (!bus.cpu_req || m_cpu_won_last);
    m_cpu_wins  = !rst && bus.cpu_req && !m_eng_wins;
    e_addr = 0; e_wdata = 0; e_wstrb = 0; e_read_en = 0;
    if (m_eng_wins) begin
      e_addr = CLAIM_ADDR;
      if (m_claim_pend) e_read_en = 1;
      else begin e_wdata = 32'(m_id); e_wstrb = 4'hF; end
    end else if (m_cpu_wins) begin
      e_addr = bus.cpu_addr; e_wdata = bus.cpu_wdata;
      e_wstrb = bus.cpu_wstrb; e_read_en = bus.cpu_read_en;
    end
    e_cpu_ready = m_cpu_wins;
    e_cpu_rdata = m_cpu_wins ? bus.plic_rdata : 32'h0;
    e_irq_valid = !rst && m_holding;
    e_irq_id    = e_irq_valid ? 5'(m_id) : 5'd0;
  endfunction

  function automatic void model_update();
    int old_hold;
    if (rst) begin
      model_reset();
      return;
    end
    model_predict();
    old_hold = m_holdoff;
    if (m_eng_wants && bus.cpu_req) m_cpu_won_last = m_cpu_wins;
    if (m_compl_pend && m_eng_wins) m_holdoff = HOLDOFF;
    else if (m_holdoff > 0)         m_holdoff = m_holdoff - 1;
    if (m_claim_pend && m_eng_wins) begin
      m_claim_pend = 0;
      m_id = int'(bus.plic_rdata[4:0]);
      if (m_id == 0) m_spur = (m_spur < 255) ? m_spur + 1 : 255;
      else begin m_holding = 1; m_claims = (m_claims + 1) % 65536; end
    end else if (m_compl_pend && m_eng_wins) begin
      m_compl_pend = 0;
    end else if (m_holding && bus.done_valid && int'(bus.done_id) == m_id) begin
      m_holding = 0;
      m_compl_pend = 1;
    end else if (!m_claim_pend && !m_holding && !m_compl_pend &&
                 bus.engine_en && bus.plic_external_irq && old_hold == 0) begin
      m_claim_pend = 1;
    end
  endfunction

  task automatic compare_all();
    model_predict();
    chk("cpu_ready",    32'(bus.cpu_ready),      32'(e_cpu_ready));
    chk("cpu_rdata",    bus.cpu_rdata,           e_cpu_rdata);
    chk("plic_addr",    bus.plic_addr,           e_addr);
    chk("plic_wdata",   bus.plic_wdata,          e_wdata);
    chk("plic_wstrb",   32'(bus.plic_wstrb),     32'(e_wstrb));
    chk("plic_read_en", 32'(bus.plic_read_en),   32'(e_read_en));
    chk("irq_valid",    32'(bus.irq_valid),      32'(e_irq_valid));
    chk("irq_id",       32'(bus.irq_id),         32'(e_irq_id));
    chk("claim_count",  32'(bus.claim_count),    rst ? 32'd0 : 32'(m_claims));
    chk("spur_count",   32'(bus.spurious_count), rst ? 32'd0 : 32'(m_spur));
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    int n;
    int seen;
    rst = 1'b1;
    bus.cpu_req = 0; bus.cpu_read_en = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0; bus.cpu_wstrb = 0;
    bus.plic_rdata = 0; bus.plic_external_irq = 0; bus.engine_en = 0;
    bus.done_valid = 0; bus.done_id = 0;
    model_reset();
    #1;
    // Reset state
    chk("rst_irq_valid", 32'(bus.irq_valid), 0);
    chk("rst_cpu_ready", 32'(bus.cpu_ready), 0);
    chk("rst_plic_addr", bus.plic_addr, 0);
    tick(); tick();
    rst = 1'b0;

    // Spurious claim: ID 0 returned
    bus.engine_en = 1; bus.plic_external_irq = 1; bus.plic_rdata = 32'h0;
    tick();
    chk("spur_claim_read", 32'(bus.plic_read_en), 1);
    tick();
    chk("spur_count_1", 32'(bus.spurious_count), 1);
    chk("spur_claims_0", 32'(bus.claim_count), 0);
    chk("spur_no_irq", 32'(bus.irq_valid), 0);

    // Claim of source 5 while the CPU contends for the port
    bus.plic_rdata = 32'hABCD_E005;
    bus.cpu_req = 1; bus.cpu_read_en = 1; bus.cpu_addr = 32'h0C00_2000; bus.cpu_wstrb = 4'h0;
    tick();
    chk("arb1_cpu_ready", 32'(bus.cpu_ready), 0);
    chk("arb1_read_en", 32'(bus.plic_read_en), 1);
    chk("arb1_addr", bus.plic_addr, 32'h0C200004);
    tick();
    chk("present_valid", 32'(bus.irq_valid), 1);
    chk("present_id", 32'(bus.irq_id), 5);
    chk("claims_1", 32'(bus.claim_count), 1);
    chk("uncontested_cpu", 32'(bus.cpu_ready), 1);
    bus.done_valid = 1; bus.done_id = 5'd7;
    tick();
    chk("wrong_done_ignored", 32'(bus.irq_valid), 1);
    bus.done_id = 5'd5;
    tick();
    chk("arb2_cpu_ready", 32'(bus.cpu_ready), 1);
    chk("arb2_addr", bus.plic_addr, 32'h0C002000);
    chk("arb2_irq_cleared", 32'(bus.irq_valid), 0);
    bus.done_valid = 0;
    tick();
    chk("arb3_cpu_ready", 32'(bus.cpu_ready), 0);
    chk("complete_wstrb", 32'(bus.plic_wstrb), 32'hF);
    chk("complete_wdata", bus.plic_wdata, 5);
    chk("complete_read_en", 32'(bus.plic_read_en), 0);
    bus.cpu_req = 0; bus.plic_rdata = 32'h9;
    tick();
    n = 1;
    chk("holdoff_c1", 32'(bus.plic_read_en), 0);
    for (int i = 0; i < 8 && !bus.plic_read_en; i++) begin
      tick();
      n++;
    end
    chk("holdoff_gap", n, 4);
    tick();
    chk("claims_2", 32'(bus.claim_count), 2);
    chk("present_id9", 32'(bus.irq_id), 9);

    // engine_en dropped while presenting
    bus.engine_en = 0; bus.done_valid = 1; bus.done_id = 5'd9;
    tick();
    bus.done_valid = 0;
    chk("dis_complete_wdata", bus.plic_wdata, 9);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.plic_read_en) seen++;
    end
    chk("dis_no_claim", seen, 0);
    chk("dis_claims", 32'(bus.claim_count), 2);

    // Reset asserted while presenting
    bus.engine_en = 1; bus.plic_rdata = 32'h3;
    n = 0;
    while (!bus.irq_valid && n < 12) begin
      tick();
      n++;
    end
    chk("reach_present", 32'(bus.irq_valid), 1);
    bus.cpu_req = 1;
    rst = 1'b1;
    #1;
    chk("mid_rst_irq_valid", 32'(bus.irq_valid), 0);
    chk("mid_rst_irq_id", 32'(bus.irq_id), 0);
    chk("mid_rst_cpu_ready", 32'(bus.cpu_ready), 0);
    chk("mid_rst_cpu_rdata", bus.cpu_rdata, 0);
    chk("mid_rst_read_en", 32'(bus.plic_read_en), 0);
    chk("mid_rst_addr", bus.plic_addr, 0);
    tick();
    rst = 1'b0;
    bus.cpu_req = 0; bus.engine_en = 0; bus.plic_external_irq = 0;
    bus.done_valid = 1; bus.done_id = 5'd3;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.plic_wstrb != 4'h0) seen++;
    end
    chk("post_rst_no_complete", seen, 0);
    chk("post_rst_claims", 32'(bus.claim_count), 0);
    chk("post_rst_spur", 32'(bus.spurious_count), 0);

    // Spurious counter saturation
    bus.done_valid = 0; bus.engine_en = 1; bus.plic_external_irq = 1; bus.plic_rdata = 32'h0;
    for (int i = 0; i < 600; i++) tick();
    chk("spur_saturated", 32'(bus.spurious_count), 255);
    chk("spur_sat_claims", 32'(bus.claim_count), 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst                   = ($urandom_range(0, 199) == 0);
      bus.engine_en         = ($urandom_range(0, 9) < 8);
      bus.plic_external_irq = ($urandom_range(0, 1) == 1);
      bus.cpu_req           = ($urandom_range(0, 9) < 4);
      bus.cpu_read_en       = 1'($urandom);
      bus.cpu_addr          = $urandom;
      bus.cpu_wdata         = $urandom;
      bus.cpu_wstrb         = 4'($urandom);
      bus.plic_rdata        = $urandom;
      if ($urandom_range(0, 4) == 0) bus.plic_rdata[4:0] = 5'd0;
      bus.done_valid        = ($urandom_range(0, 9) < 3);
      bus.done_id           = ($urandom_range(0, 9) < 6) ? 5'(m_id) : 5'($urandom);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
